// File: rtl/countdown_timer_if.sv
// Command and status bundle for the BCD HH:MM:SS countdown timer.
// Handshake: command strobes are single-cycle pulses sampled on the clock edge; no ready side exists, every strobe is consumed the cycle it is seen.
interface countdown_timer_if;
    logic        load;
    logic [23:0] load_bcd;
    logic        start;
    logic        pause;
    logic        clear;
    logic [23:0] time_bcd;
    logic        running;
    logic        done;
    logic        alarm;
    logic        load_err;
    logic [1:0]  state_dbg;

    modport master (
        output load, load_bcd, start, pause, clear,
        input  time_bcd, running, done, alarm, load_err, state_dbg
    );

    modport slave (
        input  load, load_bcd, start, pause, clear,
        output time_bcd, running, done, alarm, load_err, state_dbg
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD HH:MM:SS countdown timer: loads a start time, counts down once per tick,
// raises done/alarm on reaching 00:00:00.
module countdown_timer #(
    parameter int TICK_DIV = 50000000
) (
    input logic            CLOCK_50,
    input logic            RESET_N,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [23:0]   cur_time;
    logic          running_r;
    logic          done_r;
    logic          alarm_r;
    logic          load_err_r;
    logic          load_ok;

    function automatic logic valid_bcd(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        return (h0 <= 4'd9) && (m0 <= 4'd9) && (s0 <= 4'd9) &&
               (s1 <= 4'd5) && (m1 <= 4'd5) && (h1 <= 4'd2) &&
               ((h1 != 4'd2) || (h0 <= 4'd3));
    endfunction

    // Borrow ripples upward only while the lower digit is already zero.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd0) s0 = s0 - 4'd1;
        else begin
            s0 = 4'd9;
            if (s1 != 4'd0) s1 = s1 - 4'd1;
            else begin
                s1 = 4'd5;
                if (m0 != 4'd0) m0 = m0 - 4'd1;
                else begin
                    m0 = 4'd9;
                    if (m1 != 4'd0) m1 = m1 - 4'd1;
                    else begin
                        m1 = 4'd5;
                        if (h0 != 4'd0) h0 = h0 - 4'd1;
                        else begin
                            h0 = 4'd9;
                            h1 = h1 - 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    assign load_ok = bus.load && (state != RUN) && valid_bcd(bus.load_bcd);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state      <= IDLE;
            presc      <= '0;
            cur_time   <= '0;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            alarm_r    <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
            if (bus.clear) begin
                state     <= IDLE;
                presc     <= '0;
                cur_time  <= '0;
                running_r <= 1'b0;
                alarm_r   <= 1'b0;
            end else if (load_ok) begin
                state     <= IDLE;
                presc     <= '0;
                cur_time  <= bus.load_bcd;
                running_r <= 1'b0;
                alarm_r   <= 1'b0;
            end else begin
                // A rejected load does not block pause/start or the running count.
                if (bus.load) load_err_r <= 1'b1;
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.pause && (cur_time != 24'h0)) begin
                            state     <= RUN;
                            presc     <= '0;
                            running_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state     <= PAUSED;
                            running_r <= 1'b0;
                        end else if (presc == PRESC_MAX) begin
                            presc    <= '0;
                            cur_time <= bcd_dec(cur_time);
                            if (cur_time == 24'h000001) begin
                                state     <= EXPIRED;
                                running_r <= 1'b0;
                                alarm_r   <= 1'b1;
                                done_r    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (bus.start && !bus.pause) begin
                            state     <= RUN;
                            running_r <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.time_bcd  = cur_time;
    assign bus.running   = running_r;
    assign bus.done      = done_r;
    assign bus.alarm     = alarm_r;
    assign bus.load_err  = load_err_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: seconds-based reference model, directed scenarios and randomized strobes.
module tb_countdown_timer;
    localparam int TICK = 4;
    localparam int MI = 0, MR = 1, MP = 2, ME = 3;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    countdown_timer_if bus();

    countdown_timer #(.TICK_DIV(TICK)) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time as plain seconds, mode, run cycles since last tick.
    int m_secs = 0;
    int m_mode = MI;
    int m_ph   = 0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    logic [23:0] exp_q[$];
    logic [27:0] act_vec;
    assign act_vec = {bus.time_bcd, bus.running, bus.done, bus.alarm, bus.load_err};

    function automatic logic [23:0] secs_to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int bcd_to_secs(input logic [23:0] v);
        int h, m, x;
        h = int'(v[23:20]) * 10 + int'(v[19:16]);
        m = int'(v[15:12]) * 10 + int'(v[11:8]);
        x = int'(v[7:4]) * 10 + int'(v[3:0]);
        return h * 3600 + m * 60 + x;
    endfunction

    function automatic bit bcd_ok(input logic [23:0] v);
        for (int i = 0; i < 6; i++)
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return (int'(v[23:20]) * 10 + int'(v[19:16]) <= 23) && (v[15:12] <= 4'd5) && (v[7:4] <= 4'd5);
    endfunction

    function automatic logic [27:0] exp_vec();
        return {secs_to_bcd(m_secs), m_mode == MR, m_done, m_mode == ME, m_err};
    endfunction

    task automatic model_step();
        if (!RESET_N) begin
            m_secs = 0; m_mode = MI; m_ph = 0; m_done = 0; m_err = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (bus.clear) begin
            m_secs = 0; m_ph = 0; m_mode = MI;
        end else if (bus.load && m_mode != MR && bcd_ok(bus.load_bcd)) begin
            m_secs = bcd_to_secs(bus.load_bcd); m_ph = 0; m_mode = MI;
        end else begin
            if (bus.load) m_err = 1;
            if (bus.pause) begin
                if (m_mode == MR) m_mode = MP;
            end else if (m_mode == MR) begin
                m_ph++;
                if (m_ph == TICK) begin
                    m_ph = 0;
                    m_secs--;
                    if (m_secs == 0) begin m_mode = ME; m_done = 1; end
                end
            end else if (bus.start) begin
                if (m_mode == MI && m_secs != 0) begin m_mode = MR; m_ph = 0; end
                else if (m_mode == MP) m_mode = MR;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        bus.start = 1'b1;
        cycle();
        cycle();
        checks++;
        if (act_vec !== 28'h0) begin errors++; $display("FAIL reset_outputs: got %h exp %h", act_vec, 28'h0); end
        checks++;
        if (act_vec !== exp_vec()) begin errors++; $display("FAIL reset_model: got %h exp %h", act_vec, exp_vec()); end
        RESET_N = 1'b1;
        cycle();
    endtask

    task automatic test_countdown();
        int done_at;
        logic [23:0] prev;
        done_at = -1;
        exp_q = {24'h000002, 24'h000001, 24'h000000};
        bus.load_bcd = 24'h000003; bus.load = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        prev = bus.time_bcd;
        for (int n = 1; n <= 16; n++) begin
            cycle();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL countdown_c%0d: got %h exp %h", n, act_vec, exp_vec()); end
            if (bus.time_bcd !== prev) begin
                checks++;
                if (exp_q.size() == 0 || bus.time_bcd !== exp_q[0]) begin
                    errors++; $display("FAIL countdown_seq: got %h exp %h", bus.time_bcd, exp_q.size() ? exp_q[0] : 24'hx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                prev = bus.time_bcd;
            end
            if (bus.done === 1'b1) done_at = n;
        end
        checks++;
        if (done_at !== 12) begin errors++; $display("FAIL done_latency: got %0d exp 12", done_at); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL countdown_left: got %0d exp 0", exp_q.size()); end
        bus.start = 1'b1;
        cycle();
        checks++;
        if (bus.alarm !== 1'b1 || bus.running !== 1'b0) begin
            errors++; $display("FAIL expired_start: got alarm=%b running=%b exp 1 0", bus.alarm, bus.running);
        end
    endtask

    task automatic test_borrow();
        bus.load_bcd = 24'h100000; bus.load = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        for (int n = 0; n < TICK; n++) begin
            cycle();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL borrow_hr: got %h exp %h", act_vec, exp_vec()); end
        end
        checks++;
        if (bus.time_bcd !== 24'h095959) begin errors++; $display("FAIL borrow_10h: got %h exp 095959", bus.time_bcd); end
        bus.pause = 1'b1;
        cycle();
        bus.load_bcd = 24'h000100; bus.load = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        for (int n = 0; n < TICK; n++) cycle();
        checks++;
        if (bus.time_bcd !== 24'h000059) begin errors++; $display("FAIL borrow_min: got %h exp 000059", bus.time_bcd); end
    endtask

    task automatic test_load_limits();
        logic [23:0] vals[6];
        bit          acc[6];
        logic [23:0] last_ok;
        vals = '{24'h235959, 24'h240000, 24'h006000, 24'h000060, 24'h0A0000, 24'h190000};
        acc  = '{1, 0, 0, 0, 0, 1};
        bus.clear = 1'b1;
        cycle();
        last_ok = 24'h0;
        for (int i = 0; i < 6; i++) begin
            bus.load_bcd = vals[i]; bus.load = 1'b1;
            cycle();
            if (acc[i]) last_ok = vals[i];
            checks++;
            if (bus.load_err !== !acc[i] || bus.time_bcd !== last_ok) begin
                errors++; $display("FAIL load_limit_%h: got err=%b time=%h exp err=%b time=%h", vals[i], bus.load_err, bus.time_bcd, !acc[i], last_ok);
            end
            cycle();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL load_after_%h: got %h exp %h", vals[i], act_vec, exp_vec()); end
        end
    endtask

    task automatic test_pause();
        int lat;
        logic [23:0] prev;
        bus.load_bcd = 24'h000010; bus.load = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        for (int n = 0; n < TICK; n++) cycle();
        cycle();
        cycle();
        bus.pause = 1'b1;
        cycle();
        for (int n = 0; n < 20; n++) begin
            cycle();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL paused_hold: got %h exp %h", act_vec, exp_vec()); end
        end
        prev = bus.time_bcd;
        bus.start = 1'b1;
        cycle();
        lat = -1;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            cycle();
            if (bus.time_bcd !== prev) lat = n;
        end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL resume_latency: got %0d exp 2", lat); end
    endtask

    task automatic test_load_in_run();
        logic [23:0] prev;
        prev = bus.time_bcd;
        bus.load_bcd = 24'h000100; bus.load = 1'b1;
        cycle();
        checks++;
        if (bus.load_err !== 1'b1 || bus.running !== 1'b1 || bus.time_bcd !== prev) begin
            errors++; $display("FAIL load_in_run: got err=%b run=%b time=%h exp 1 1 %h", bus.load_err, bus.running, bus.time_bcd, prev);
        end
        for (int n = 0; n < 8; n++) begin
            cycle();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL run_continue: got %h exp %h", act_vec, exp_vec()); end
        end
    endtask

    task automatic test_clear_load();
        bus.clear = 1'b1; bus.load = 1'b1; bus.load_bcd = 24'h000500;
        cycle();
        checks++;
        if (act_vec !== 28'h0) begin errors++; $display("FAIL clear_load: got %h exp %h", act_vec, 28'h0); end
    endtask

    task automatic test_reset_mid_run();
        bus.load_bcd = 24'h000005; bus.load = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        for (int n = 0; n < 6; n++) cycle();
        RESET_N = 1'b0; bus.start = 1'b1; bus.load = 1'b1; bus.load_bcd = 24'h000009;
        cycle();
        RESET_N = 1'b1;
        checks++;
        if (act_vec !== 28'h0) begin errors++; $display("FAIL reset_mid_run: got %h exp %h", act_vec, 28'h0); end
        bus.start = 1'b1;
        cycle();
        checks++;
        if (bus.running !== 1'b0 || bus.time_bcd !== 24'h0) begin
            errors++; $display("FAIL start_at_zero: got run=%b time=%h exp 0 000000", bus.running, bus.time_bcd);
        end
    endtask

    task automatic test_back_to_back();
        bus.load_bcd = 24'h000001; bus.load = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        for (int n = 0; n < TICK; n++) cycle();
        bus.load_bcd = 24'h000002; bus.load = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        for (int n = 0; n < 3 * TICK; n++) begin
            cycle();
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL back_to_back: got %h exp %h", act_vec, exp_vec()); end
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 3000; n++) begin
            RESET_N   = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            bus.clear = ($urandom_range(0, 99) < 2);
            bus.load  = ($urandom_range(0, 99) < 6);
            bus.pause = ($urandom_range(0, 99) < 5);
            bus.start = ($urandom_range(0, 99) < 15);
            r = $urandom_range(0, 3);
            if (r < 2)       bus.load_bcd = secs_to_bcd($urandom_range(0, 12));
            else if (r == 2) bus.load_bcd = secs_to_bcd($urandom_range(0, 86399));
            else             bus.load_bcd = 24'($urandom);
            cycle();
            RESET_N = 1'b1;
            checks++;
            if (act_vec !== exp_vec()) begin errors++; $display("FAIL random_c%0d: got %h exp %h", n, act_vec, exp_vec()); end
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.load_bcd = 24'h0; bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        test_reset();
        test_countdown();
        test_borrow();
        test_load_limits();
        test_pause();
        test_load_in_run();
        test_clear_load();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
